// File: rtl/ula_pipe_n_bits.sv
// Registered WIDTH-bit ULA with valid/ready handshakes on both sides.
// Define ULA_MUL_EN to add the multi-cycle shift-and-add unsigned multiplier (m=0, s=1100).
module ula_pipe_n_bits #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_hi,
    output logic             a_eq_b,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    logic [WIDTH-1:0] addend;
    logic             carry_in;
    logic             use_adder;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_f;
    logic             res_c;
    logic             res_v;
    logic             accept;
    logic             is_mul;
    logic             load_mul;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_hi;
    logic             mul_eq;

    // Every arithmetic code is one adder: subtract and decrement just pick a different addend.
    always_comb begin
        addend    = '0;
        carry_in  = 1'b0;
        use_adder = 1'b0;
        if (!m) begin
            case (s)
                4'b0101: begin addend = b;    carry_in = c_in;  use_adder = 1'b1; end
                4'b1000: begin addend = ~b;   carry_in = !c_in; use_adder = 1'b1; end
                4'b0000: begin addend = '0;   carry_in = c_in;  use_adder = 1'b1; end
                4'b1111: begin addend = '1;   carry_in = c_in;  use_adder = 1'b1; end
                default: ;
            endcase
        end
    end

    assign sum = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};

    always_comb begin
        res_f = a;
        res_c = 1'b0;
        res_v = 1'b0;
        if (!m) begin
            if (use_adder) begin
                res_f = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
        end else begin
            case (s)
                4'b0000: res_f = ~a;
                4'b0001: res_f = ~(a | b);
                4'b0100: res_f = ~(a & b);
                4'b0110: res_f = a ^ b;
                4'b1001: res_f = ~(a ^ b);
                4'b1011: res_f = a & b;
                4'b1110: res_f = a | b;
                4'b1111: res_f = a;
                4'b0011: res_f = '0;
                4'b1100: res_f = '1;
                default: res_f = b;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

`ifdef ULA_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   count;
    logic [WIDTH:0]     partial;

    assign is_mul   = !m && (s == 4'b1100);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst;
    assign load_mul = (state == DONE);
    assign mul_lo   = acc[WIDTH-1:0];
    assign mul_hi   = acc[2*WIDTH-1:WIDTH];

    // The multiplier sits in the low half of acc and shifts out as product bits shift in.
    assign partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_mul) state_next = MUL;
            MUL:     if (count == CNT_W'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            count  <= '0;
            mul_eq <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept && is_mul) begin
                mcand  <= a;
                acc    <= {{WIDTH{1'b0}}, b};
                count  <= '0;
                mul_eq <= (a == b);
            end else if (state == MUL) begin
                acc   <= {partial, acc[WIDTH-1:1]};
                count <= count + CNT_W'(1);
            end
        end
    end
`else
    assign is_mul   = 1'b0;
    assign in_ready = (!out_valid || out_ready) && !rst;
    assign load_mul = 1'b0;
    assign mul_lo   = '0;
    assign mul_hi   = '0;
    assign mul_eq   = 1'b0;
    assign f_hi     = '0;
`endif

    // Result registers only change on a load; otherwise they hold through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            f         <= '0;
`ifdef ULA_MUL_EN
            f_hi      <= '0;
`endif
            a_eq_b    <= 1'b0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (load_mul) begin
            out_valid <= 1'b1;
            f         <= mul_lo;
`ifdef ULA_MUL_EN
            f_hi      <= mul_hi;
`endif
            a_eq_b    <= mul_eq;
            c_out     <= |mul_hi;
            overflow  <= 1'b0;
            zero      <= (mul_lo == '0);
            negative  <= mul_lo[WIDTH-1];
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            f         <= res_f;
`ifdef ULA_MUL_EN
            f_hi      <= '0;
`endif
            a_eq_b    <= (a == b);
            c_out     <= res_c;
            overflow  <= res_v;
            zero      <= (res_f == '0);
            negative  <= res_f[WIDTH-1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ula_pipe_n_bits.sv
// Self-checking bench for ula_pipe_n_bits: directed spec cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_ula_pipe_n_bits;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, m, c_in, out_valid, out_ready;
    logic [W-1:0] a, b, f, f_hi;
    logic [3:0]   s;
    logic         a_eq_b, c_out, overflow, zero, negative;

    logic         in_valid16, in_ready16, m16, c_in16, out_valid16, out_ready16;
    logic [15:0]  a16, b16, f16, f_hi16;
    logic [3:0]   s16;
    logic         a_eq_b16, c_out16, overflow16, zero16, negative16;

    ula_pipe_n_bits #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .f(f), .f_hi(f_hi),
        .a_eq_b(a_eq_b), .c_out(c_out), .overflow(overflow), .zero(zero), .negative(negative)
    );

    ula_pipe_n_bits #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .s(s16), .m(m16), .c_in(c_in16),
        .out_valid(out_valid16), .out_ready(out_ready16), .f(f16), .f_hi(f_hi16),
        .a_eq_b(a_eq_b16), .c_out(c_out16), .overflow(overflow16), .zero(zero16),
        .negative(negative16)
    );

    typedef struct packed {
        logic [W-1:0] f;
        logic [W-1:0] f_hi;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        logic         eq;
    } res_t;

    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    res_t exp_r = '0;
    res_t pend_r = '0;
    bit   exp_valid = 1'b0;
    int   mul_left = 0;

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic [3:0] is, input logic im, input logic ic);
        res_t   r;
        longint lim, ua, ub, sa, sb, u, sr, prod, ci;
        bit     arith;
        lim   = longint'(1) << W;
        ua    = longint'(ia);
        ub    = longint'(ib);
        sa    = ia[W-1] ? ua - lim : ua;
        sb    = ib[W-1] ? ub - lim : ub;
        ci    = ic ? 1 : 0;
        r     = '0;
        arith = 1'b0;
        u     = 0;
        sr    = 0;
        r.f   = ia;
        if (!im) begin
            case (is)
                4'b0101: begin u = ua + ub + ci; sr = sa + sb + ci; arith = 1'b1; r.c = (u >= lim); end
                4'b1000: begin u = ua - ub - ci; sr = sa - sb - ci; arith = 1'b1; r.c = (u >= 0); end
                4'b0000: begin u = ua + ci;      sr = sa + ci;      arith = 1'b1; r.c = (u >= lim); end
                4'b1111: begin u = ua - 1 + ci;  sr = sa - 1 + ci;  arith = 1'b1; r.c = (u >= 0); end
`ifdef ULA_MUL_EN
                4'b1100: begin
                    prod   = ua * ub;
                    r.f    = prod[W-1:0];
                    r.f_hi = prod[2*W-1:W];
                    r.c    = (r.f_hi != 0);
                end
`endif
                default: r.f = ia;
            endcase
            if (arith) begin
                r.f = u[W-1:0];
                r.v = (sr > lim / 2 - 1) || (sr < -(lim / 2));
            end
        end else begin
            case (is)
                4'h0: r.f = ~ia;
                4'h1: r.f = ~(ia | ib);
                4'h4: r.f = ~(ia & ib);
                4'h6: r.f = ia ^ ib;
                4'h9: r.f = ~(ia ^ ib);
                4'hB: r.f = ia & ib;
                4'hE: r.f = ia | ib;
                4'hF: r.f = ia;
                4'h3: r.f = '0;
                4'hC: r.f = '1;
                default: r.f = ib;
            endcase
        end
        r.z  = (r.f == 0);
        r.n  = r.f[W-1];
        r.eq = (ia == ib);
        return r;
    endfunction

    function automatic bit exp_ir();
        return !rst && (mul_left == 0) && (!exp_valid || out_ready);
    endfunction

    task automatic model_step();
        bit   acc_now;
        bit   load;
        res_t r;
        load = 1'b0;
        r    = '0;
        if (rst) begin
            exp_r     = '0;
            exp_valid = 1'b0;
            mul_left  = 0;
        end else begin
            acc_now = exp_ir() && in_valid;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    load = 1'b1;
                    r    = pend_r;
                end
            end else if (acc_now) begin
                r    = model(a, b, s, m, c_in);
                load = 1'b1;
`ifdef ULA_MUL_EN
                if (!m && s == 4'b1100) begin
                    pend_r   = r;
                    mul_left = W + 1;
                    load     = 1'b0;
                end
`endif
            end
            if (load) begin
                exp_r     = r;
                exp_valid = 1'b1;
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic [3:0] ss, input bit mm, input bit cc, input bit ordy);
        @(posedge clk);
        #2;
        in_valid  = v;
        a         = aa;
        b         = bb;
        s         = ss;
        m         = mm;
        c_in      = cc;
        out_ready = ordy;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checkOutput("cyc_in_ready",  32'(in_ready),  32'(exp_ir()));
            checkOutput("cyc_out_valid", 32'(out_valid), 32'(exp_valid));
            checkOutput("cyc_f",         32'(f),         32'(exp_r.f));
            checkOutput("cyc_f_hi",      32'(f_hi),      32'(exp_r.f_hi));
            checkOutput("cyc_c_out",     32'(c_out),     32'(exp_r.c));
            checkOutput("cyc_overflow",  32'(overflow),  32'(exp_r.v));
            checkOutput("cyc_zero",      32'(zero),      32'(exp_r.z));
            checkOutput("cyc_negative",  32'(negative),  32'(exp_r.n));
            checkOutput("cyc_a_eq_b",    32'(a_eq_b),    32'(exp_r.eq));
        end
    end

    initial begin
        in_valid = 0; a = '0; b = '0; s = '0; m = 0; c_in = 0; out_ready = 1;
        in_valid16 = 0; a16 = '0; b16 = '0; s16 = '0; m16 = 0; c_in16 = 0; out_ready16 = 1;
        rst = 1'b1;

        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_f", 32'(f), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(1, 8'h7F, 8'h01, 4'b0101, 0, 0, 1);
        applyStimulus(0, 8'h00, 8'h00, 4'b0000, 0, 0, 1);
        @(negedge clk);
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_f", 32'(f), 32'h80);
        checkOutput("add_c", 32'(c_out), 32'd0);
        checkOutput("add_v", 32'(overflow), 32'd1);
        checkOutput("add_n", 32'(negative), 32'd1);
        checkOutput("add_z", 32'(zero), 32'd0);

        applyStimulus(1, 8'h80, 8'h01, 4'b1000, 0, 0, 1);
        applyStimulus(1, 8'h05, 8'h0A, 4'b1000, 0, 0, 1);
        @(negedge clk);
        checkOutput("sub1_f", 32'(f), 32'h7F);
        checkOutput("sub1_c", 32'(c_out), 32'd1);
        checkOutput("sub1_v", 32'(overflow), 32'd1);
        applyStimulus(0, 8'h00, 8'h00, 4'b0000, 0, 0, 1);
        @(negedge clk);
        checkOutput("sub2_f", 32'(f), 32'hFB);
        checkOutput("sub2_c", 32'(c_out), 32'd0);
        checkOutput("sub2_v", 32'(overflow), 32'd0);

        applyStimulus(1, 8'h10, 8'h20, 4'b0101, 0, 0, 0);
        applyStimulus(1, 8'h0F, 8'hF0, 4'b0110, 1, 0, 0);
        @(negedge clk);
        checkOutput("bp_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_f", 32'(f), 32'h30);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 8'h0F, 8'hF0, 4'b0110, 1, 0, 0);
        @(negedge clk);
        checkOutput("bp_hold_f", 32'(f), 32'h30);
        checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 8'h0F, 8'hF0, 4'b0110, 1, 0, 1);
        @(negedge clk);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(0, 8'h00, 8'h00, 4'b0000, 0, 0, 1);
        @(negedge clk);
        checkOutput("bp_second_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_second_f", 32'(f), 32'hFF);
        checkOutput("bp_second_n", 32'(negative), 32'd1);

`ifdef ULA_MUL_EN
        applyStimulus(1, 8'hFF, 8'hFF, 4'b1100, 0, 0, 1);
        applyStimulus(0, 8'h00, 8'h00, 4'b0000, 0, 0, 1);
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            checkOutput("mul_wait_valid", 32'(out_valid), 32'd0);
            checkOutput("mul_wait_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        checkOutput("mul_valid", 32'(out_valid), 32'd1);
        checkOutput("mul_f", 32'(f), 32'h01);
        checkOutput("mul_f_hi", 32'(f_hi), 32'hFE);
        checkOutput("mul_c", 32'(c_out), 32'd1);

        applyStimulus(1, 8'hC3, 8'h5A, 4'b1100, 0, 0, 1);
        applyStimulus(0, 8'h00, 8'h00, 4'b0000, 0, 0, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("mulrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("mulrst_valid", 32'(out_valid), 32'd0);
        checkOutput("mulrst_f", 32'(f), 32'd0);
        checkOutput("mulrst_f_hi", 32'(f_hi), 32'd0);
        checkOutput("mulrst_after_in_ready", 32'(in_ready), 32'd1);
        repeat (W + 4) begin
            @(negedge clk);
            checkOutput("mulrst_no_stale", 32'(out_valid), 32'd0);
        end
`else
        applyStimulus(1, 8'hFF, 8'hFF, 4'b1100, 0, 0, 1);
        applyStimulus(0, 8'h00, 8'h00, 4'b0000, 0, 0, 1);
        @(negedge clk);
        checkOutput("nomul_valid", 32'(out_valid), 32'd1);
        checkOutput("nomul_f", 32'(f), 32'hFF);
        checkOutput("nomul_f_hi", 32'(f_hi), 32'd0);
`endif

        applyStimulus(1, 8'h01, 8'h02, 4'b0101, 0, 0, 0);
        applyStimulus(0, 8'h00, 8'h00, 4'b0000, 0, 0, 0);
        @(negedge clk);
        checkOutput("pend_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("pend_discard_valid", 32'(out_valid), 32'd0);
        checkOutput("pend_discard_f", 32'(f), 32'd0);

        @(posedge clk);
        #2;
        in_valid16 = 1; a16 = 16'h1234; b16 = 16'h1234; m16 = 1; s16 = 4'b0110;
        @(posedge clk);
        #2 b16 = 16'h9234;
        @(negedge clk);
        checkOutput("w16_f", 32'(f16), 32'h0000);
        checkOutput("w16_zero", 32'(zero16), 32'd1);
        checkOutput("w16_eq", 32'(a_eq_b16), 32'd1);
        @(posedge clk);
        #2 in_valid16 = 0;
        @(negedge clk);
        checkOutput("w16_f2", 32'(f16), 32'h8000);
        checkOutput("w16_eq2", 32'(a_eq_b16), 32'd0);
        checkOutput("w16_neg2", 32'(negative16), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h80;
            if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) != 0) ? 8'hFF : a;
            s         = 4'($urandom);
            m         = 1'($urandom);
            c_in      = 1'($urandom);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (W + 4) applyStimulus(0, 8'h00, 8'h00, 4'b0000, 0, 0, 1);
        @(negedge clk);
        #1 chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
